// File: rtl/kbd_source_arbiter.sv
// Merges UART and USB keystrokes into the Apple-1 KBD/KBDCR register through per-source FIFOs.
// Uses round-robin arbitration and a post-read gap. Optional upper-casing is enabled by KBD_UPCASE_EN.
module kbd_source_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic [1:0] src_en,
  input  logic       uart_stb,
  input  logic [7:0] uart_byte,
  input  logic       usb_stb,
  input  logic [7:0] usb_byte,
  input  logic       kbd_rd,
  input  logic       ovf_clr,
  output logic       kbd_ready,
  output logic [6:0] kbd_data,
  output logic [1:0] ovf
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             kbd_ready_q, kbd_ready_d;
  logic [6:0]       kbd_data_q, kbd_data_d;
  logic [1:0]       ovf_q, ovf_d;
  logic [6:0]       mem_q [2][FIFO_DEPTH];
  logic [6:0]       mem_d [2][FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q [2];
  logic [PTR_W-1:0] wptr_d [2];
  logic [PTR_W-1:0] rptr_q [2];
  logic [PTR_W-1:0] rptr_d [2];
  logic [CNT_W-1:0] count_q [2];
  logic [CNT_W-1:0] count_d [2];

  logic [1:0] stb, elig, push, pop, full;
  logic [6:0] in_byte [2];
  logic       grant;
  logic       unused_bit7;

  // Bit 7 of each received byte is dropped by design.
  assign unused_bit7 = uart_byte[7] ^ usb_byte[7];

  function automatic logic [6:0] cond_byte(input logic [6:0] b);
    logic [6:0] c;
    c = b;
`ifdef KBD_UPCASE_EN
    if (c >= 7'h61 && c <= 7'h7A) c = c - 7'h20;
`endif
    return c;
  endfunction

  always_comb begin
    stb        = {usb_stb, uart_stb};
    in_byte[0] = cond_byte(uart_byte[6:0]);
    in_byte[1] = cond_byte(usb_byte[6:0]);
    for (int i = 0; i < 2; i++) begin
      full[i] = (count_q[i] == FULL_CNT);
      elig[i] = src_en[i] && (count_q[i] != '0);
    end
    // On a tie, the source that did not win last time is served.
    if (elig == 2'b11) grant = ~last_grant_q;
    else               grant = elig[1];
    pop = 2'b00;
    if (state_q == IDLE && elig != 2'b00) pop[grant] = 1'b1;

    ovf_d = ovf_clr ? 2'b00 : ovf_q;
    mem_d = mem_q;
    for (int i = 0; i < 2; i++) begin
      push[i]    = stb[i] && src_en[i] && !full[i];
      wptr_d[i]  = wptr_q[i];
      rptr_d[i]  = rptr_q[i];
      count_d[i] = count_q[i];
      if (stb[i] && src_en[i] && full[i]) ovf_d[i] = 1'b1;
      if (!src_en[i]) begin
        wptr_d[i]  = '0;
        rptr_d[i]  = '0;
        count_d[i] = '0;
      end else begin
        if (push[i]) begin
          mem_d[i][wptr_q[i]] = in_byte[i];
          wptr_d[i] = wptr_q[i] + PTR_W'(1);
        end
        if (pop[i]) rptr_d[i] = rptr_q[i] + PTR_W'(1);
        count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end

    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    last_grant_d = last_grant_q;
    kbd_ready_d  = kbd_ready_q;
    kbd_data_d   = kbd_data_q;
    case (state_q)
      IDLE: begin
        if (elig != 2'b00) begin
          kbd_data_d   = mem_q[grant][rptr_q[grant]];
          kbd_ready_d  = 1'b1;
          last_grant_d = grant;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (kbd_rd) begin
          kbd_ready_d = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk25) begin
    mem_q <= mem_d;
    if (rst) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      kbd_ready_q  <= 1'b0;
      kbd_data_q   <= '0;
      ovf_q        <= 2'b00;
      wptr_q       <= '{default: '0};
      rptr_q       <= '{default: '0};
      count_q      <= '{default: '0};
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      last_grant_q <= last_grant_d;
      kbd_ready_q  <= kbd_ready_d;
      kbd_data_q   <= kbd_data_d;
      ovf_q        <= ovf_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
    end
  end

  assign kbd_ready = kbd_ready_q;
  assign kbd_data  = kbd_data_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_kbd_source_arbiter.sv
// Directed bench for kbd_source_arbiter: a per-cycle vector table plus hand-written
// sequences for overflow, flush, upper-casing and reset-in-HOLD.
module tb_kbd_source_arbiter;
  logic       clk25 = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] src_en = 2'b11;
  logic       uart_stb = 1'b0;
  logic [7:0] uart_byte = 8'h00;
  logic       usb_stb = 1'b0;
  logic [7:0] usb_byte = 8'h00;
  logic       kbd_rd = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       kbd_ready;
  logic [6:0] kbd_data;
  logic [1:0] ovf;

  int checks = 0;
  int failures = 0;

  kbd_source_arbiter #(.FIFO_DEPTH(4), .GAP_CYCLES(16)) dut (
    .clk25(clk25), .rst(rst), .src_en(src_en),
    .uart_stb(uart_stb), .uart_byte(uart_byte),
    .usb_stb(usb_stb), .usb_byte(usb_byte),
    .kbd_rd(kbd_rd), .ovf_clr(ovf_clr),
    .kbd_ready(kbd_ready), .kbd_data(kbd_data), .ovf(ovf)
  );

  always #5 clk25 = ~clk25;

  typedef struct {
    logic       rst;
    logic [1:0] en;
    logic       us;
    logic [7:0] ub;
    logic       vs;
    logic [7:0] vb;
    logic       rd;
    logic       clr;
    logic       e_rdy;
    logic [6:0] e_data;
    logic [1:0] e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] en, input logic us, input logic [7:0] ub,
                     input logic vs, input logic [7:0] vb, input logic rd, input logic clr,
                     input logic erdy, input logic [6:0] edata, input logic [1:0] eovf);
    vec_t v;
    v.rst = r; v.en = en; v.us = us; v.ub = ub; v.vs = vs; v.vb = vb;
    v.rd = rd; v.clr = clr; v.e_rdy = erdy; v.e_data = edata; v.e_ovf = eovf;
    vecs.push_back(v);
  endtask

  task automatic idle_row(input logic erdy, input logic [6:0] edata);
    add(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, erdy, edata, 2'b00);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic clear_pulses();
    rst = 1'b0; uart_stb = 1'b0; usb_stb = 1'b0; kbd_rd = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    clear_pulses();
    src_en = 2'b11;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_uart(input logic [7:0] b);
    uart_stb = 1'b1; uart_byte = b;
    tick();
    uart_stb = 1'b0;
  endtask

  task automatic send_usb(input logic [7:0] b);
    usb_stb = 1'b1; usb_byte = b;
    tick();
    usb_stb = 1'b0;
  endtask

  task automatic pulse_rd();
    kbd_rd = 1'b1;
    tick();
    kbd_rd = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int max_cycles);
    int n;
    n = 0;
    while (kbd_ready !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    chk({name, "_ready"}, kbd_ready, 1'b1);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (kbd_ready === 1'b1) seen = 1'b1;
    end
    chk(name, seen, 1'b0);
  endtask

  initial begin
    logic [6:0] up_exp;

    // Single key, read, and 16-cycle gap before the next key
    add(1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00, 2'b00);
    add(1'b0, 2'b11, 1'b1, 8'h41, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00, 2'b00);
    idle_row(1'b1, 7'h41);
    idle_row(1'b1, 7'h41);
    add(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'h41, 2'b00);
    add(1'b0, 2'b11, 1'b1, 8'h42, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h41, 2'b00);
    for (int i = 0; i < 15; i++) idle_row(1'b0, 7'h41);
    idle_row(1'b1, 7'h42);
    add(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'h42, 2'b00);

    // Round-robin: simultaneous strobes, UART wins first, then alternation
    add(1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00, 2'b00);
    add(1'b0, 2'b11, 1'b1, 8'h31, 1'b1, 8'h32, 1'b0, 1'b0, 1'b0, 7'h00, 2'b00);
    idle_row(1'b1, 7'h31);
    add(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'h31, 2'b00);
    for (int i = 0; i < 16; i++) idle_row(1'b0, 7'h31);
    idle_row(1'b1, 7'h32);
    add(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'h32, 2'b00);
    add(1'b0, 2'b11, 1'b1, 8'h34, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 7'h32, 2'b00);
    for (int i = 0; i < 15; i++) idle_row(1'b0, 7'h32);
    idle_row(1'b1, 7'h34);
    add(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'h34, 2'b00);
    for (int i = 0; i < 16; i++) idle_row(1'b0, 7'h34);
    idle_row(1'b1, 7'h33);
    add(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'h33, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; src_en = vecs[i].en;
      uart_stb = vecs[i].us; uart_byte = vecs[i].ub;
      usb_stb = vecs[i].vs; usb_byte = vecs[i].vb;
      kbd_rd = vecs[i].rd; ovf_clr = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_ready", i), kbd_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d_data", i), kbd_data, vecs[i].e_data);
      chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].e_ovf);
    end
    clear_pulses();

    // Overflow: one key in KBD, four queued, sixth dropped
    do_reset();
    for (int k = 0; k < 5; k++) send_uart(8'h41 + 8'(k));
    chk("ovf_fill_ready", kbd_ready, 1'b1);
    chk("ovf_fill_data", kbd_data, 7'h41);
    chk("ovf_fill_ovf", ovf, 2'b00);
    send_uart(8'h46);
    chk("ovf_set", ovf, 2'b01);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 2'b00);
    ovf_clr = 1'b1; send_uart(8'h47); ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf, 2'b01);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr2", ovf, 2'b00);
    for (int k = 0; k < 5; k++) begin
      wait_ready($sformatf("ovf_rd%0d", k), 40);
      chk($sformatf("ovf_rd%0d_data", k), kbd_data, 7'h41 + 7'(k));
      pulse_rd();
    end
    expect_quiet("ovf_no_extra", 40);

    // Case conversion of a bit7-set lower-case byte
`ifdef KBD_UPCASE_EN
    up_exp = 7'h41;
`else
    up_exp = 7'h61;
`endif
    do_reset();
    send_uart(8'hE1);
    tick();
    chk("upcase_ready", kbd_ready, 1'b1);
    chk("upcase_data", kbd_data, up_exp);

    // Disabling USB flushes its FIFO and ignores strobes; KBD key unaffected
    do_reset();
    send_uart(8'h50);
    tick();
    chk("flush_hold_data", kbd_data, 7'h50);
    send_usb(8'h52);
    send_usb(8'h53);
    src_en = 2'b01;
    send_usb(8'h54);
    tick();
    chk("flush_kbd_ready", kbd_ready, 1'b1);
    chk("flush_kbd_data", kbd_data, 7'h50);
    chk("flush_ovf", ovf, 2'b00);
    src_en = 2'b11;
    send_usb(8'h55);
    pulse_rd();
    wait_ready("flush_next", 40);
    chk("flush_next_data", kbd_data, 7'h55);
    pulse_rd();
    expect_quiet("flush_no_stale", 40);

    // Reset while holding a key with a full, overflowed USB FIFO
    do_reset();
    send_uart(8'h41);
    tick();
    for (int k = 0; k < 5; k++) send_usb(8'h60 + 8'(k));
    chk("rst_pre_ovf", ovf, 2'b10);
    chk("rst_pre_ready", kbd_ready, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_ready", kbd_ready, 1'b0);
    chk("rst_data", kbd_data, 7'h00);
    chk("rst_ovf", ovf, 2'b00);
    expect_quiet("rst_fifos_empty", 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
